move_sort_reader: RTL

Consumer-side drain engine for the move sorter. It waits for the sorter's `sort_complete`, then reads the sorted move RAM through the sorter's external read port (`ram_rd_addr`/`ram_rd_data`) in ascending address order. Entries are presented to the search engine as a valid/ready stream. After the last entry is accepted, or on abort, it pulses `sort_clear` to return the sorter to idle. Internal prefetch buffering hides the RAM read latency and sustains one entry per clock.

---
 rtl/move_sort_reader_if.sv | 37 +++
 rtl/move_sort_reader.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/move_sort_reader_if.sv
// Output stream of the move sort reader.
// Master drives entries; slave drives ready.
interface move_sort_reader_if #(
  parameter int RAM_WIDTH  = 32,
  parameter int EVAL_WIDTH = 16,
  parameter int AW         = 8
);

  logic                         out_valid;
  logic                         out_ready;
  logic [RAM_WIDTH-1:0]         out_data;
  logic signed [EVAL_WIDTH-1:0] out_eval;
  logic                         out_pv;
  logic [AW-1:0]                out_index;
  logic                         out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_eval,
    output out_pv,
    output out_index,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_eval,
    input  out_pv,
    input  out_index,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/move_sort_reader.sv
// Drains the sorted move RAM as a valid/ready stream.
// Credit-limited prefetch hides the RAM read latency.
`ifndef MAX_POSITIONS
`define MAX_POSITIONS 256
`endif

module move_sort_reader #(
  parameter int RAM_WIDTH          = 32,
  parameter int EVAL_WIDTH         = 16,
  parameter int MAX_POSITIONS_LOG2 = $clog2(`MAX_POSITIONS),
  parameter int RD_LATENCY         = 2,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [MAX_POSITIONS_LOG2-1:0] move_count,
  input  logic                          abort,
  input  logic                          sort_complete,
  output logic                          sort_clear,
  output logic [MAX_POSITIONS_LOG2-1:0] ram_rd_addr,
  input  logic [RAM_WIDTH-1:0]          ram_rd_data,
  move_sort_reader_if.master            out_if,
  output logic                          busy,
  output logic                          done
);

  localparam int AW = MAX_POSITIONS_LOG2;
  localparam int FW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = FW + 1;
  localparam int EW = RAM_WIDTH + AW;

  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_CLEAR  = 2'd3;

  logic [1:0]          state_q, state_d;
  logic                start_z_q, start_z_d;
  logic [AW-1:0]       n_q, n_d;
  logic [AW:0]         rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [RD_LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [AW-1:0]       tag_idx_q [RD_LATENCY];
  logic [AW-1:0]       tag_idx_d [RD_LATENCY];
  logic [EW-1:0]       fifo_mem_q [FIFO_DEPTH];
  logic [EW-1:0]       fifo_mem_d [FIFO_DEPTH];
  logic [FW-1:0]       wr_idx_q, wr_idx_d;
  logic [FW-1:0]       rd_idx_q, rd_idx_d;
  logic [CW-1:0]       count_q, count_d;

  logic                start_rise;
  logic [CW:0]         inflight;
  logic [CW:0]         used;
  logic                issue;
  logic                push;
  logic                pop;
  logic                flush;
  logic                last_pop;
  logic                valid_w;
  logic                last_w;
  logic [EW-1:0]       head;
  logic [RAM_WIDTH-1:0] data_w;
  logic [AW-1:0]       index_w;

  assign start_rise = start & ~start_z_q;
  assign start_z_d  = start;

  // Reads in flight plus buffered entries bound the credit window.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + (CW+1)'(tag_vld_q[i]);
    end
    used = {1'b0, count_q} + inflight;
  end

  assign issue = (state_q == S_STREAM) && !abort &&
                 (rd_ptr_q < {1'b0, n_q}) &&
                 (used < DEPTH_C);

  assign push = (state_q == S_STREAM) && !abort &&
                tag_vld_q[RD_LATENCY-1];

  assign head    = fifo_mem_q[rd_idx_q];
  assign valid_w = (count_q != '0);
  assign data_w  = valid_w ? head[EW-1:AW] : '0;
  assign index_w = valid_w ? head[AW-1:0] : '0;
  assign last_w  = valid_w && (index_w == n_q - AW'(1));

  assign pop      = valid_w && out_if.out_ready;
  assign last_pop = pop && last_w;

  assign out_if.out_valid = valid_w;
  assign out_if.out_data  = data_w;
  assign out_if.out_eval  = data_w[EVAL_WIDTH-1:0];
  assign out_if.out_pv    = data_w[EVAL_WIDTH+3];
  assign out_if.out_index = index_w;
  assign out_if.out_last  = last_w;

  assign sort_clear = (state_q == S_CLEAR);
  assign done       = (state_q == S_CLEAR);
  assign busy       = (state_q != S_IDLE);

  assign ram_rd_addr = issue ? rd_ptr_q[AW-1:0] : addr_q;
  assign addr_d      = (state_q == S_CLEAR) ? '0 : ram_rd_addr;

  // Control FSM: wait, stream, then release the sorter.
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    rd_ptr_d = rd_ptr_q;
    flush    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_rise) begin
          n_d      = move_count;
          rd_ptr_d = '0;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort) begin
          state_d = S_CLEAR;
        end else if (sort_complete) begin
          state_d = (n_q == '0) ? S_CLEAR : S_STREAM;
        end
      end
      S_STREAM: begin
        if (issue) begin
          rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
        if (abort) begin
          flush   = 1'b1;
          state_d = S_CLEAR;
        end else if (last_pop) begin
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Tag pipe follows each read through the RAM latency.
  always_comb begin
    tag_vld_d[0] = issue;
    tag_idx_d[0] = rd_ptr_q[AW-1:0];
    for (int i = 1; i < RD_LATENCY; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_idx_d[i] = tag_idx_q[i-1];
    end
    if (flush) begin
      tag_vld_d = '0;
    end
  end

  // Prefetch FIFO; credits keep it from overflowing.
  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_idx_d   = wr_idx_q;
    rd_idx_d   = rd_idx_q;
    if (push) begin
      fifo_mem_d[wr_idx_q] = {ram_rd_data,
                              tag_idx_q[RD_LATENCY-1]};
      wr_idx_d = wr_idx_q + FW'(1);
    end
    if (pop) begin
      rd_idx_d = rd_idx_q + FW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);
    if (flush) begin
      wr_idx_d = '0;
      rd_idx_d = '0;
      count_d  = '0;
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      start_z_q <= 1'b0;
      n_q       <= '0;
      rd_ptr_q  <= '0;
      addr_q    <= '0;
      tag_vld_q <= '0;
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      start_z_q <= start_z_d;
      n_q       <= n_d;
      rd_ptr_q  <= rd_ptr_d;
      addr_q    <= addr_d;
      tag_vld_q <= tag_vld_d;
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
      count_q   <= count_d;
    end
  end

  // Datapath storage; qualified by the valid flags above.
  always_ff @(posedge clk) begin
    tag_idx_q  <= tag_idx_d;
    fifo_mem_q <= fifo_mem_d;
  end

endmodule
